// File: rtl/dsm_ser_pkg.sv
`default_nettype none
//==============================================================================
// dsm_ser_pkg -- shared FSM states and CRC-8 helper for dsm_frame_serializer
// Rev 1.0
//==============================================================================
package dsm_ser_pkg;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_STRB = 3'd1,
      ST_LEAD = 3'd2,
      ST_BYTE = 3'd3
`ifdef DSM_SER_CRC_EN
      ,
      ST_CRCB = 3'd4
`endif
   } ser_state_t;

   // One byte folded into the running CRC, MSB first.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dsm_frame_serializer_if.sv
`default_nettype none
//==============================================================================
// dsm_frame_serializer_if -- frame input handshake and serialized byte output
// Rev 1.0
//==============================================================================
interface dsm_frame_serializer_if #(
   parameter int DATA_W = 24,
   parameter int N_CH   = 2
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                     in_valid;
   logic                     in_ready;
   logic [N_CH*DATA_W-1:0]   in_data;
   logic [7:0]               out_byte;
   logic                     out_strobe;
   logic [CH_W-1:0]          out_ch;
   logic                     busy;
   logic                     overflow;

   modport master (
      output in_valid, in_data,
      input  in_ready, out_byte, out_strobe, out_ch, busy, overflow
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, out_byte, out_strobe, out_ch, busy, overflow
   );
endinterface
`default_nettype wire

// File: rtl/dsm_frame_fifo.sv
`default_nettype none
//==============================================================================
// dsm_frame_fifo -- synchronous first-word-fall-through FIFO, power-of-2 depth
// Rev 1.0
//==============================================================================
module dsm_frame_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   input  wire logic                   push,
   input  wire logic                   pop,
   input  wire logic [WIDTH-1:0]       din,
   output logic      [WIDTH-1:0]       dout,
   output logic                        full,
   output logic                        empty,
   output logic      [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == (PTR_W+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/dsm_frame_serializer.sv
`default_nettype none
//==============================================================================
// dsm_frame_serializer -- frame FIFO feeding a strobed byte serializer;
// define DSM_SER_CRC_EN to append a CRC-8 trailer byte per frame.  Rev 1.0
//==============================================================================
module dsm_frame_serializer
   import dsm_ser_pkg::*;
#(
   parameter int DATA_W     = 24,
   parameter int N_CH       = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int BYTE_HOLD  = 4,
   parameter int LEAD_CYC   = 2
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   dsm_frame_serializer_if.slave bus
);
   localparam int FRAME_W = N_CH * DATA_W;
   localparam int N_BYTES = DATA_W / 8;
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

   ser_state_t         r_state;
   ser_state_t         w_state_nxt;
   logic               w_pop;
   logic               w_push;
   logic               w_strobe;
   logic [7:0]         w_byte;

   logic [FRAME_W-1:0] w_fifo_dout;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [CNT_W-1:0]   w_fifo_count;
   logic               w_have_frame;

   logic [FRAME_W-1:0] r_shreg;
   logic [CH_W-1:0]    r_ch_cnt;
   logic [2:0]         r_byte_cnt;
   logic [7:0]         r_hold_cnt;
   logic [7:0]         r_lead_cnt;
   logic               r_overflow;
`ifdef DSM_SER_CRC_EN
   logic [7:0]         r_crc;
`endif

   logic w_last_hold;
   logic w_last_byte;
   logic w_last_ch;
   logic w_last_lead;

   assign w_push       = bus.in_valid && !w_fifo_full;
   assign w_have_frame = !w_fifo_empty && (w_fifo_count != '0);

   dsm_frame_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (bus.in_data),
      .dout  (w_fifo_dout),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (w_fifo_count)
   );

   assign w_last_hold = (r_hold_cnt == 8'(BYTE_HOLD - 1));
   assign w_last_byte = (r_byte_cnt == 3'(N_BYTES - 1));
   assign w_last_ch   = (r_ch_cnt == CH_W'(N_CH - 1));
   assign w_last_lead = (r_lead_cnt == 8'(LEAD_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_strobe    = 1'b0;
      w_byte      = 8'h00;
      case (r_state)
         ST_IDLE: begin
            if (w_have_frame) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_STRB;
            end
         end
         ST_STRB: begin
            w_strobe    = 1'b1;
            w_state_nxt = (LEAD_CYC == 0) ? ST_BYTE : ST_LEAD;
         end
         ST_LEAD: begin
            if (w_last_lead) w_state_nxt = ST_BYTE;
         end
         ST_BYTE: begin
            w_byte = r_shreg[DATA_W-1 -: 8];
            if (w_last_hold && w_last_byte) begin
               if (!w_last_ch) begin
                  w_state_nxt = ST_STRB;
               end else begin
`ifdef DSM_SER_CRC_EN
                  w_state_nxt = ST_CRCB;
`else
                  // Frame end: chain straight into the next frame when one waits.
                  w_pop       = w_have_frame;
                  w_state_nxt = w_have_frame ? ST_STRB : ST_IDLE;
`endif
               end
            end
         end
`ifdef DSM_SER_CRC_EN
         ST_CRCB: begin
            w_byte = r_crc;
            if (w_last_hold) begin
               w_pop       = w_have_frame;
               w_state_nxt = w_have_frame ? ST_STRB : ST_IDLE;
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shreg    <= '0;
         r_ch_cnt   <= '0;
         r_byte_cnt <= '0;
         r_hold_cnt <= '0;
         r_lead_cnt <= '0;
         r_overflow <= 1'b0;
`ifdef DSM_SER_CRC_EN
         r_crc      <= 8'h00;
`endif
      end else begin
         if (bus.in_valid && w_fifo_full) r_overflow <= 1'b1;
         case (r_state)
            ST_STRB: begin
               r_lead_cnt <= '0;
               r_hold_cnt <= '0;
               r_byte_cnt <= '0;
            end
            ST_LEAD: r_lead_cnt <= r_lead_cnt + 8'd1;
            ST_BYTE: begin
               if (w_last_hold) begin
                  r_hold_cnt <= '0;
`ifdef DSM_SER_CRC_EN
                  r_crc <= crc8_update(r_crc, r_shreg[DATA_W-1 -: 8]);
`endif
                  // Current word sits in the low DATA_W bits; its MSB byte is emitted.
                  r_shreg[DATA_W-1:0] <= r_shreg[DATA_W-1:0] << 8;
                  if (w_last_byte) begin
                     r_byte_cnt <= '0;
                     if (!w_last_ch) begin
                        r_ch_cnt <= r_ch_cnt + 1'b1;
                        r_shreg  <= r_shreg >> DATA_W;
                     end
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 3'd1;
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
`ifdef DSM_SER_CRC_EN
            ST_CRCB: r_hold_cnt <= w_last_hold ? 8'd0 : r_hold_cnt + 8'd1;
`endif
            default: ;
         endcase
         if (w_pop) begin
            r_shreg  <= w_fifo_dout;
            r_ch_cnt <= '0;
`ifdef DSM_SER_CRC_EN
            r_crc    <= 8'h00;
`endif
         end
      end
   end

   assign bus.in_ready   = !w_fifo_full;
   assign bus.out_byte   = w_byte;
   assign bus.out_strobe = w_strobe;
   assign bus.out_ch     = r_ch_cnt;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: doc/dsm_frame_serializer.md
DSM_FRAME_SERIALIZER -- requirements
Module: dsm_frame_serializer

Interface
REQ-001 Parameter DATA_W, 24, sample width per channel; SHALL be a multiple of 8, range 8..32.
REQ-002 Parameter N_CH, 2, channels per frame, range 1..8.
REQ-003 Parameter FIFO_DEPTH, 4, frame FIFO depth; SHALL be a power of 2, range 2..16.
REQ-004 Parameter BYTE_HOLD, 4, clock cycles each output byte is held, range 1..255.
REQ-005 Parameter LEAD_CYC, 2, cycles between word strobe and first byte, range 0..255.
REQ-006 Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  frame offered.
- in_ready  out  1  FIFO not full.
- in_data  in  N_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
- out_byte  out  8  serialized byte.
- out_strobe  out  1  one-cycle word-start pulse.
- out_ch  out  max(1,clog2(N_CH))  channel of current word.
- busy  out  1  serializer not IDLE.
- overflow  out  1  sticky frame-drop flag.

Function
REQ-007 Push on in_valid && in_ready; in_ready = !full, from the registered FIFO count.
REQ-008 in_valid while !in_ready: frame dropped, FIFO unchanged, overflow set to 1 until reset.
REQ-009 FSM states are IDLE, STRB, LEAD, BYTE and, with CRC only, CRCB.
REQ-010 IDLE with FIFO non-empty: pop the head frame into the shift register and go to STRB next cycle.
REQ-011 Latency: push at edge t into an empty FIFO while IDLE gives out_strobe=1 in cycle t+1.
REQ-012 STRB lasts 1 cycle with out_strobe=1 and out_byte=0x00; then LEAD for LEAD_CYC cycles, skipped if 0, with out_byte=0x00.
REQ-013 BYTE emits DATA_W/8 bytes MSB first, each held exactly BYTE_HOLD cycles.
REQ-014 Word length SHALL be 1+LEAD_CYC+(DATA_W/8)*BYTE_HOLD cycles; words go out ch0..ch(N_CH-1), back to back.
REQ-015 out_ch = index of current word, constant from its STRB to its last BYTE cycle.
REQ-016 Frame end with FIFO non-empty: pop and enter STRB on the next cycle, with no IDLE gap; otherwise go to IDLE, out_byte=0x00, busy=0.
REQ-017 Push and pop in the same cycle are both honoured; count is unchanged.
REQ-018 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-019 busy = 1 in every state except IDLE.

Reset
REQ-020 rst_n=0 at an edge, including mid-frame: FSM to IDLE, FIFO emptied, shift register cleared, no resume.
REQ-021 Reset values: out_byte=0x00, out_strobe=0, out_ch=0, busy=0, overflow=0, in_ready=1 on the first cycle after reset.

Configuration
REQ-022 With DSM_SER_CRC_EN defined, CRCB follows the last word of each frame.
- CRCB byte = CRC-8 (poly 0x07, init 0x00, MSB first) over all frame bytes in emission order.
- Held BYTE_HOLD cycles; out_strobe=0; out_ch holds N_CH-1.
REQ-023 Without DSM_SER_CRC_EN: no CRCB state and no CRC logic; frame length = N_CH words.

Structure
REQ-024 Package dsm_ser_pkg SHALL hold:
- FSM state enum.
- CRC8_POLY=8'h07.
- CRC-8 byte-update function.
REQ-025 Sub-module dsm_frame_fifo (synchronous, parametrised width/depth, full/empty/count outputs) holds the frame FIFO; serializer FSM stays in the top module.

Verification
Defaults unless noted: DATA_W=24, N_CH=2, FIFO_DEPTH=4, BYTE_HOLD=4, LEAD_CYC=2.
REQ-026 Reset: rst_n low 2 cycles -> all outputs at REQ-021 values, in_ready=1.
REQ-027 Push ch0=0x123456, ch1=0xABCDEF at t:
- strobe at t+1 (out_ch=0); 0x12 t+4..t+7, 0x34 t+8..t+11, 0x56 t+12..t+15.
- strobe at t+16 (out_ch=1); AB, CD, EF t+19..t+30.
- busy=0 at t+31.
REQ-028 Six pushes at t..t+5 -> first frame popped at t+1; pushes 1-5 accepted; in_ready=0 at t+5, sixth dropped, overflow=1; all five frames emitted contiguously, first strobe t+1, then every 15 cycles.
REQ-029 rst_n low during the second byte of ch0 -> next cycle out_byte=0x00, busy=0; FIFO empty; no further strobes.
REQ-030 DSM_SER_CRC_EN, ch0=0x000000, ch1=0x000001 -> after byte 0x01, out_byte=0x07 for 4 cycles, out_strobe=0; then IDLE.
REQ-031 LEAD_CYC=0, BYTE_HOLD=1, N_CH=1, DATA_W=8, data 0xA5 pushed at t -> strobe t+1, 0xA5 at t+2 only, busy=0 at t+3.
